// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, ALU encodings, sequencer states and instruction field positions
package core_pkg;

   localparam int PC_W_DEF    = 5;
   localparam int INSTR_W_DEF = 32;
   localparam int DATA_W_DEF  = 16;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 24;
   localparam int RS_HI  = 23;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 18;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_AND  = 5'h03;
   localparam logic [4:0] OP_OR   = 5'h04;
   localparam logic [4:0] OP_XOR  = 5'h05;
   localparam logic [4:0] OP_ADDI = 5'h06;
   localparam logic [4:0] OP_LDI  = 5'h07;
   localparam logic [4:0] OP_STI  = 5'h08;
   localparam logic [4:0] OP_BEQ  = 5'h09;
   localparam logic [4:0] OP_BGT  = 5'h0A;
   localparam logic [4:0] OP_JMP  = 5'h0B;
   localparam logic [4:0] OP_HALT = 5'h1F;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_PASSB = 4'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_HALT
   } state_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction word to datapath control bundle decode
module instr_decoder
   import core_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic [INSTR_W-1:0] instr,
   output logic [2:0]         rs_addr,
   output logic [2:0]         rt_addr,
   output logic [2:0]         rd_addr,
   output logic [DATA_W-1:0]  imm_data,
   output logic [DATA_W-1:0]  mem_data,
   output logic [3:0]         alu_sel,
   output logic               imm_sel,
   output logic               mem_write,
   output logic               is_wb,
   output logic               is_branch,
   output logic               is_jump,
   output logic               is_halt,
   output logic               is_illegal
);

   logic [4:0]        opcode;
   logic [DATA_W-1:0] imm;
   logic              uses_fields;
   logic              unused_rsvd;

   assign opcode      = instr[OPC_HI:OPC_LO];
   assign imm         = DATA_W'(instr[IMM_HI:IMM_LO]);
   assign unused_rsvd = ^instr[17:16];
   // Only opcodes that feed the datapath expose their register/immediate fields.
   assign uses_fields = (opcode >= OP_ADD) && (opcode <= OP_BGT);

   always_comb begin
      rs_addr    = '0;
      rt_addr    = '0;
      rd_addr    = '0;
      imm_data   = '0;
      mem_data   = '0;
      alu_sel    = ALU_ADD;
      imm_sel    = 1'b0;
      mem_write  = 1'b0;
      is_wb      = 1'b0;
      is_branch  = 1'b0;
      is_jump    = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      if (uses_fields) begin
         rs_addr  = instr[RS_HI:RS_LO];
         rt_addr  = instr[RT_HI:RT_LO];
         rd_addr  = instr[RD_HI:RD_LO];
         imm_data = imm;
      end
      case (opcode)
         OP_NOP:  ;
         OP_ADD:  begin is_wb = 1'b1; alu_sel = ALU_ADD; end
         OP_SUB:  begin is_wb = 1'b1; alu_sel = ALU_SUB; end
         OP_AND:  begin is_wb = 1'b1; alu_sel = ALU_AND; end
         OP_OR:   begin is_wb = 1'b1; alu_sel = ALU_OR;  end
         OP_XOR:  begin is_wb = 1'b1; alu_sel = ALU_XOR; end
         OP_ADDI: begin is_wb = 1'b1; alu_sel = ALU_ADD;   imm_sel = 1'b1; end
         OP_LDI:  begin is_wb = 1'b1; alu_sel = ALU_PASSB; imm_sel = 1'b1; end
         OP_STI:  begin mem_write = 1'b1; mem_data = imm; end
         OP_BEQ,
         OP_BGT:  begin is_branch = 1'b1; alu_sel = ALU_SUB; end
         OP_JMP:  is_jump = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - FETCH/DECODE/EXEC/WB sequencer driving the 16-bit datapath control bundle
module datapath_sequencer
   import core_pkg::*;
#(
   parameter int PC_W     = PC_W_DEF,
   parameter int INSTR_W  = INSTR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RESET_PC = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               zero_flag,
   input  logic               pos_flag,
   output logic               rf_write,
   output logic [2:0]         rs_addr,
   output logic [2:0]         rt_addr,
   output logic [2:0]         rd_addr,
   output logic [DATA_W-1:0]  imm_data,
   output logic [3:0]         alu_sel,
   output logic               imm_sel,
   output logic               mem_write,
   output logic [DATA_W-1:0]  mem_data,
   output logic [PC_W-1:0]    PC_out,
   output logic [4:0]         opcode_out,
   output logic               halted,
   output logic               illegal
);

   state_t              state_q;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INSTR_W-1:0]  ir_q, dec_instr;
   logic [2:0]          rs_q, rt_q, rd_q;
   logic [DATA_W-1:0]   imm_q, mem_data_q;
   logic [3:0]          alu_q;
   logic                imm_sel_q, rf_write_q, mem_write_q, halted_q, illegal_q;

   logic [2:0]          dec_rs, dec_rt, dec_rd;
   logic [DATA_W-1:0]   dec_imm, dec_mem_data;
   logic [3:0]          dec_alu;
   logic                dec_imm_sel, dec_mem_write, dec_wb, dec_branch, dec_jump, dec_halt, dec_illegal;
   logic                taken, clear_ctrl;

   // Decode the ROM word while it is being latched so the bundle is registered on entry to EXEC.
   assign dec_instr = (state_q == ST_DECODE) ? imem_data : ir_q;

   instr_decoder #(.INSTR_W(INSTR_W), .DATA_W(DATA_W)) u_dec (
      .instr      (dec_instr),
      .rs_addr    (dec_rs),
      .rt_addr    (dec_rt),
      .rd_addr    (dec_rd),
      .imm_data   (dec_imm),
      .mem_data   (dec_mem_data),
      .alu_sel    (dec_alu),
      .imm_sel    (dec_imm_sel),
      .mem_write  (dec_mem_write),
      .is_wb      (dec_wb),
      .is_branch  (dec_branch),
      .is_jump    (dec_jump),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal)
   );

   assign taken      = dec_jump | (dec_branch & ((ir_q[OPC_HI:OPC_LO] == OP_BEQ) ? zero_flag : pos_flag));
   assign pc_d       = taken ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
   assign clear_ctrl = ((state_q == ST_EXEC) && !dec_wb) || (state_q == ST_WB);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= PC_W'(RESET_PC);
         ir_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         mem_data_q  <= '0;
         alu_q       <= ALU_ADD;
         imm_sel_q   <= 1'b0;
         rf_write_q  <= 1'b0;
         mem_write_q <= 1'b0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE:   if (run) state_q <= ST_FETCH;
            ST_FETCH:  state_q <= ST_DECODE;
            ST_DECODE: begin
               ir_q        <= imem_data;
               state_q     <= ST_EXEC;
               rs_q        <= dec_rs;
               rt_q        <= dec_rt;
               rd_q        <= dec_rd;
               imm_q       <= dec_imm;
               mem_data_q  <= dec_mem_data;
               alu_q       <= dec_alu;
               imm_sel_q   <= dec_imm_sel;
               mem_write_q <= dec_mem_write;
               if (dec_illegal) illegal_q <= 1'b1;
            end
            ST_EXEC: begin
               if (dec_halt) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else if (dec_wb) begin
                  state_q    <= ST_WB;
                  rf_write_q <= 1'b1;
               end else begin
                  pc_q    <= pc_d;
                  state_q <= run ? ST_FETCH : ST_IDLE;
               end
            end
            ST_WB: begin
               pc_q    <= pc_d;
               state_q <= run ? ST_FETCH : ST_IDLE;
            end
            default: ;
         endcase
         // Leaving the instruction (or entering HALT) returns the whole bundle to zero.
         if (clear_ctrl) begin
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            mem_data_q  <= '0;
            alu_q       <= ALU_ADD;
            imm_sel_q   <= 1'b0;
            rf_write_q  <= 1'b0;
            mem_write_q <= 1'b0;
         end
      end
   end

   assign imem_addr  = pc_q;
   assign PC_out     = pc_q;
   assign opcode_out = ir_q[OPC_HI:OPC_LO];
   assign rf_write   = rf_write_q;
   assign mem_write  = mem_write_q;
   assign rs_addr    = rs_q;
   assign rt_addr    = rt_q;
   assign rd_addr    = rd_q;
   assign imm_data   = imm_q;
   assign mem_data   = mem_data_q;
   assign alu_sel    = alu_q;
   assign imm_sel    = imm_sel_q;
   assign halted     = halted_q;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - self-checking bench for datapath_sequencer
module tb_datapath_sequencer;

   typedef struct packed {
      logic        wb;
      logic [3:0]  alu;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [2:0]  rd;
      logic        isel;
      logic [15:0] imm;
      logic        mw;
      logic [15:0] md;
      logic [4:0]  npc;
      logic        ill;
   } exp_t;

   typedef struct packed {
      logic [31:0] ins;
      logic        z;
      logic        p;
      exp_t        e;
   } vec_t;

   logic        clock, reset, run, zero_flag, pos_flag;
   logic [4:0]  imem_addr, PC_out, opcode_out;
   logic [31:0] imem_data;
   logic        rf_write, imm_sel, mem_write, halted, illegal;
   logic [2:0]  rs_addr, rt_addr, rd_addr;
   logic [15:0] imm_data, mem_data;
   logic [3:0]  alu_sel;

   logic [31:0] rom [0:31];
   logic [4:0]  m_pc;
   logic        m_ill;
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        tbl [0:14];

   datapath_sequencer dut (
      .clock(clock), .reset(reset), .run(run),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .zero_flag(zero_flag), .pos_flag(pos_flag),
      .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .imm_data(imm_data), .alu_sel(alu_sel), .imm_sel(imm_sel),
      .mem_write(mem_write), .mem_data(mem_data),
      .PC_out(PC_out), .opcode_out(opcode_out), .halted(halted), .illegal(illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) imem_data <= rom[imem_addr];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [15:0] imm);
      return {op, rd, rs, rt, 2'b00, imm};
   endfunction

   // Instruction-level reference: what one instruction does to the bundle, the PC and the sticky flag.
   function automatic exp_t model(input logic [31:0] ins, input logic [4:0] pc,
                                  input logic z, input logic p, input logic ill);
      exp_t e;
      logic [4:0] op;
      e = '0;
      op = ins[31:27];
      e.npc = pc + 5'd1;
      e.ill = ill;
      if (op >= 5'h01 && op <= 5'h0A) begin
         e.rs  = ins[23:21];
         e.rt  = ins[20:18];
         e.rd  = ins[26:24];
         e.imm = ins[15:0];
      end
      if (op >= 5'h01 && op <= 5'h05) begin
         e.wb  = 1'b1;
         e.alu = 4'(op - 5'd1);
      end else if (op == 5'h06) begin
         e.wb = 1'b1; e.isel = 1'b1;
      end else if (op == 5'h07) begin
         e.wb = 1'b1; e.isel = 1'b1; e.alu = 4'd5;
      end else if (op == 5'h08) begin
         e.mw = 1'b1; e.md = ins[15:0];
      end else if (op == 5'h09 || op == 5'h0A) begin
         e.alu = 4'd1;
         if ((op == 5'h09) ? z : p) e.npc = ins[4:0];
      end else if (op == 5'h0B) begin
         e.npc = ins[4:0];
      end else if (op != 5'h00 && op != 5'h1F) begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   // Called with the sequencer in FETCH at m_pc; returns with it in the following FETCH.
   task automatic do_instr(input string tag, input logic [31:0] ins,
                           input logic z, input logic p, input exp_t e);
      rom[m_pc] = ins;
      @(negedge clock);
      chk({tag, " dec rf_write"},  32'(rf_write),  32'd0);
      chk({tag, " dec mem_write"}, 32'(mem_write), 32'd0);
      zero_flag = z;
      pos_flag  = p;
      @(negedge clock);
      chk({tag, " ex opcode"},    32'(opcode_out), 32'(ins[31:27]));
      chk({tag, " ex alu_sel"},   32'(alu_sel),    32'(e.alu));
      chk({tag, " ex rs"},        32'(rs_addr),    32'(e.rs));
      chk({tag, " ex rt"},        32'(rt_addr),    32'(e.rt));
      chk({tag, " ex rd"},        32'(rd_addr),    32'(e.rd));
      chk({tag, " ex imm_sel"},   32'(imm_sel),    32'(e.isel));
      chk({tag, " ex imm_data"},  32'(imm_data),   32'(e.imm));
      chk({tag, " ex mem_write"}, 32'(mem_write),  32'(e.mw));
      chk({tag, " ex mem_data"},  32'(mem_data),   32'(e.md));
      chk({tag, " ex rf_write"},  32'(rf_write),   32'd0);
      if (e.wb) begin
         @(negedge clock);
         chk({tag, " wb rf_write"},  32'(rf_write),  32'd1);
         chk({tag, " wb mem_write"}, 32'(mem_write), 32'd0);
         chk({tag, " wb alu_sel"},   32'(alu_sel),   32'(e.alu));
         chk({tag, " wb rs"},        32'(rs_addr),   32'(e.rs));
         chk({tag, " wb rt"},        32'(rt_addr),   32'(e.rt));
         chk({tag, " wb rd"},        32'(rd_addr),   32'(e.rd));
         chk({tag, " wb imm_sel"},   32'(imm_sel),   32'(e.isel));
         chk({tag, " wb imm_data"},  32'(imm_data),  32'(e.imm));
      end
      @(negedge clock);
      chk({tag, " next imem_addr"}, 32'(imem_addr), 32'(e.npc));
      chk({tag, " next PC_out"},    32'(PC_out),    32'(e.npc));
      chk({tag, " fetch rf_write"}, 32'(rf_write),  32'd0);
      chk({tag, " fetch mem_wr"},   32'(mem_write), 32'd0);
      chk({tag, " fetch alu_sel"},  32'(alu_sel),   32'd0);
      chk({tag, " illegal"},        32'(illegal),   32'(e.ill));
      m_pc  = e.npc;
      m_ill = e.ill;
   endtask

   task automatic restart();
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("restart halted",  32'(halted),  32'd0);
      chk("restart illegal", 32'(illegal), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      run   = 1'b1;
      @(negedge clock);
      chk("restart fetch addr", 32'(imem_addr), 32'd0);
      m_pc  = 5'd0;
      m_ill = 1'b0;
   endtask

   initial begin
      logic [31:0] ins;
      logic [4:0]  op;
      logic        z, p;
      int          r;

      for (int i = 0; i < 32; i++) rom[i] = 32'h0;
      reset = 1'b1; run = 1'b0; zero_flag = 1'b0; pos_flag = 1'b0;
      #1 reset = 1'b0;

      tbl[0]  = '{enc(5'h07, 3'd1, 3'd0, 3'd0, 16'h0005), 1'b0, 1'b0, '{1'b1, 4'd5, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0005, 1'b0, 16'h0000, 5'd1,  1'b0}};
      tbl[1]  = '{enc(5'h01, 3'd3, 3'd1, 3'd2, 16'h0000), 1'b0, 1'b0, '{1'b1, 4'd0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd2,  1'b0}};
      tbl[2]  = '{enc(5'h08, 3'd0, 3'd3, 3'd0, 16'h00AA), 1'b0, 1'b0, '{1'b0, 4'd0, 3'd3, 3'd0, 3'd0, 1'b0, 16'h00AA, 1'b1, 16'h00AA, 5'd3,  1'b0}};
      tbl[3]  = '{enc(5'h09, 3'd0, 3'd1, 3'd2, 16'h0014), 1'b1, 1'b0, '{1'b0, 4'd1, 3'd1, 3'd2, 3'd0, 1'b0, 16'h0014, 1'b0, 16'h0000, 5'd20, 1'b0}};
      tbl[4]  = '{enc(5'h09, 3'd0, 3'd1, 3'd2, 16'h0007), 1'b0, 1'b1, '{1'b0, 4'd1, 3'd1, 3'd2, 3'd0, 1'b0, 16'h0007, 1'b0, 16'h0000, 5'd21, 1'b0}};
      tbl[5]  = '{enc(5'h0A, 3'd0, 3'd4, 3'd5, 16'h0003), 1'b0, 1'b1, '{1'b0, 4'd1, 3'd4, 3'd5, 3'd0, 1'b0, 16'h0003, 1'b0, 16'h0000, 5'd3,  1'b0}};
      tbl[6]  = '{enc(5'h0A, 3'd0, 3'd4, 3'd5, 16'h0009), 1'b1, 1'b0, '{1'b0, 4'd1, 3'd4, 3'd5, 3'd0, 1'b0, 16'h0009, 1'b0, 16'h0000, 5'd4,  1'b0}};
      tbl[7]  = '{enc(5'h0B, 3'd0, 3'd0, 3'd0, 16'hFFFF), 1'b0, 1'b0, '{1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd31, 1'b0}};
      tbl[8]  = '{enc(5'h00, 3'd7, 3'd7, 3'd7, 16'h1234), 1'b0, 1'b0, '{1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0,  1'b0}};
      tbl[9]  = '{enc(5'h10, 3'd5, 3'd5, 3'd5, 16'hBEEF), 1'b0, 1'b0, '{1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd1,  1'b1}};
      tbl[10] = '{enc(5'h06, 3'd6, 3'd5, 3'd0, 16'h8001), 1'b0, 1'b0, '{1'b1, 4'd0, 3'd5, 3'd0, 3'd6, 1'b1, 16'h8001, 1'b0, 16'h0000, 5'd2,  1'b1}};
      tbl[11] = '{enc(5'h02, 3'd2, 3'd7, 3'd0, 16'h0000), 1'b0, 1'b0, '{1'b1, 4'd1, 3'd7, 3'd0, 3'd2, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd3,  1'b1}};
      tbl[12] = '{enc(5'h03, 3'd1, 3'd2, 3'd3, 16'h0000), 1'b0, 1'b0, '{1'b1, 4'd2, 3'd2, 3'd3, 3'd1, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd4,  1'b1}};
      tbl[13] = '{enc(5'h04, 3'd4, 3'd5, 3'd6, 16'h0000), 1'b0, 1'b0, '{1'b1, 4'd3, 3'd5, 3'd6, 3'd4, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd5,  1'b1}};
      tbl[14] = '{enc(5'h05, 3'd7, 3'd6, 3'd5, 16'h0000), 1'b0, 1'b0, '{1'b1, 4'd4, 3'd6, 3'd5, 3'd7, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd6,  1'b1}};

      // Reset state
      @(negedge clock);
      chk("rst rf_write",   32'(rf_write),   32'd0);
      chk("rst mem_write",  32'(mem_write),  32'd0);
      chk("rst halted",     32'(halted),     32'd0);
      chk("rst illegal",    32'(illegal),    32'd0);
      chk("rst PC_out",     32'(PC_out),     32'd0);
      chk("rst imem_addr",  32'(imem_addr),  32'd0);
      chk("rst opcode_out", 32'(opcode_out), 32'd0);
      chk("rst alu_sel",    32'(alu_sel),    32'd0);
      chk("rst imm_data",   32'(imm_data),   32'd0);
      reset = 1'b1;
      run   = 1'b1;
      @(negedge clock);
      chk("first fetch addr", 32'(imem_addr), 32'd0);
      m_pc  = 5'd0;
      m_ill = 1'b0;

      for (int i = 0; i < 15; i++)
         do_instr($sformatf("vec%0d", i), tbl[i].ins, tbl[i].z, tbl[i].p, tbl[i].e);

      // run dropped during EXEC of a register op: WB still happens, then IDLE
      restart();
      rom[0] = enc(5'h01, 3'd3, 3'd1, 3'd2, 16'h0000);
      rom[1] = enc(5'h01, 3'd4, 3'd1, 3'd2, 16'h0000);
      @(negedge clock);
      @(negedge clock);
      run = 1'b0;
      @(negedge clock);
      chk("drop wb rf_write", 32'(rf_write), 32'd1);
      chk("drop wb rd",       32'(rd_addr),  32'd3);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk($sformatf("idle%0d PC_out", i),   32'(PC_out),   32'd1);
         chk($sformatf("idle%0d rf_write", i), 32'(rf_write), 32'd0);
      end
      run = 1'b1;
      @(negedge clock);
      chk("resume fetch addr", 32'(imem_addr), 32'd1);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      chk("pre-reset wb rf_write", 32'(rf_write), 32'd1);
      reset = 1'b0;
      #1;
      chk("async rst rf_write", 32'(rf_write),   32'd0);
      chk("async rst PC_out",   32'(PC_out),     32'd0);
      chk("async rst opcode",   32'(opcode_out), 32'd0);
      chk("async rst rd",       32'(rd_addr),    32'd0);
      @(negedge clock);
      reset = 1'b1;
      run   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("post-rst idle%0d PC_out", i), 32'(PC_out),   32'd0);
         chk($sformatf("post-rst idle%0d rf_wr", i),  32'(rf_write), 32'd0);
      end

      // Randomized instruction stream against the instruction-level model
      restart();
      for (int k = 0; k < 150; k++) begin
         r  = int'($urandom_range(0, 12));
         op = (r == 12) ? 5'($urandom_range(12, 30)) : 5'(r);
         ins = $urandom;
         ins[31:27] = op;
         z = 1'($urandom_range(0, 1));
         p = 1'($urandom_range(0, 1));
         do_instr($sformatf("rnd%0d", k), ins, z, p, model(ins, m_pc, z, p, m_ill));
      end

      // HALT at address 4
      restart();
      for (int i = 0; i < 4; i++) begin
         ins = enc(5'h00, 3'(i), 3'd1, 3'd2, 16'(i));
         do_instr($sformatf("pre-halt%0d", i), ins, 1'b0, 1'b0, model(ins, m_pc, 1'b0, 1'b0, m_ill));
      end
      rom[4] = enc(5'h1F, 3'd2, 3'd3, 3'd4, 16'h0010);
      rom[5] = enc(5'h01, 3'd3, 3'd1, 3'd2, 16'h0000);
      @(negedge clock);
      @(negedge clock);
      chk("halt ex rf_write",  32'(rf_write),  32'd0);
      chk("halt ex mem_write", 32'(mem_write), 32'd0);
      chk("halt ex halted",    32'(halted),    32'd0);
      @(negedge clock);
      chk("halt halted", 32'(halted), 32'd1);
      chk("halt PC_out", 32'(PC_out), 32'd4);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         chk($sformatf("halt%0d rf_write", i),  32'(rf_write),  32'd0);
         chk($sformatf("halt%0d mem_write", i), 32'(mem_write), 32'd0);
         chk($sformatf("halt%0d imem_addr", i), 32'(imem_addr), 32'd4);
         chk($sformatf("halt%0d halted", i),    32'(halted),    32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle instruction sequencer that drives the 16-bit datapath's control bundle (register addresses, ALU select, immediate, memory write). It fetches 32-bit instructions from a synchronous instruction ROM, decodes them, and steps FETCH/DECODE/EXEC/WB. It resolves conditional branches from the datapath zero_flag and pos_flag. It sits beside the datapath in the core and supplies the real PC_out and opcode_out.

Parameters:
PC_W, 5, program counter / instruction address width
INSTR_W, 32, instruction word width
DATA_W, 16, datapath and immediate width
RESET_PC, 0, PC value after reset

Ports:
clock  input  1  core clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  level; high lets the sequencer leave IDLE and keep issuing instructions
imem_addr  output  PC_W  instruction ROM address (equals PC)
imem_data  input  INSTR_W  ROM data, valid 1 cycle after imem_addr
zero_flag  input  1  datapath ALU result == 0, combinational in the EXEC cycle
pos_flag  input  1  datapath ALU result > 0 (signed), combinational in the EXEC cycle
rf_write  output  1  register-file write enable
rs_addr, rt_addr, rd_addr  output  3 each  register addresses
imm_data  output  DATA_W  immediate operand
alu_sel  output  4  ALU operation
imm_sel  output  1  1 = ALU B operand from imm_data
mem_write  output  1  data-memory write strobe
mem_data  output  DATA_W  data-memory write data
PC_out  output  PC_W  current PC
opcode_out  output  5  opcode held in IR
halted  output  1  HALT executed
illegal  output  1  sticky; an undefined opcode was decoded

Behaviour:
- Instruction format: [31:27] opcode, [26:24] rd, [23:21] rs, [20:18] rt, [17:16] reserved (ignored), [15:0] imm.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE: go to FETCH when run=1.
  - FETCH: drive imem_addr=PC, then DECODE.
  - DECODE: load IR from imem_data, then EXEC.
  - EXEC: to WB for register-writing ops, otherwise to FETCH, or to IDLE if run=0.
  - WB: to FETCH, or to IDLE if run=0.
  - HALT: absorbing; only reset exits.
- Outputs are Moore-style, decoded from state and IR. When not in EXEC or WB, the control bundle is 0 (rf_write=0, mem_write=0).
- Opcodes:
  - 00 NOP.
  - 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR: rd <- rs op rt.
  - 06 ADDI: rd <- rs + imm, imm_sel=1.
  - 07 LDI: rd <- imm, alu_sel=ALU_PASSB, imm_sel=1.
  - 08 STI: mem_write=1 for 1 cycle in EXEC, mem_data=imm, rs_addr=rs.
  - 09 BEQ, 0A BGT: EXEC drives SUB of rs,rt with rf_write=0; flags are sampled at the edge ending EXEC. Branch taken if zero_flag (BEQ) or pos_flag (BGT).
  - 0B JMP: PC <- imm[PC_W-1:0].
  - 1F HALT.
  - All other opcodes: executed as NOP, illegal set to 1 (sticky until reset).
- Register ops: alu_sel, rs, rt, rd, imm_sel are held stable across EXEC and WB; rf_write=1 only in WB, for exactly 1 cycle.
- Latency: ALU/ADDI/LDI take 4 cycles (F, D, E, W). NOP/STI/branch/JMP take 3 cycles. From run rising in IDLE, the first FETCH is 1 cycle later.
- PC update:
  - At the edge leaving EXEC for non-register ops, or leaving WB for register ops.
  - Taken branch/JMP: PC <- imm[PC_W-1:0]. Otherwise PC+1.
  - PC wraps from 31 to 0 with no flag.
- run deasserted mid-instruction: the instruction completes (including WB) and PC updates; the sequencer then parks in IDLE. run has no effect in FETCH or DECODE.
- HALT: in EXEC, go to HALT. halted=1 from the next cycle. PC is not incremented and keeps the HALT address. Control bundle stays 0.
- Reset (asynchronous, any state, mid-instruction included): state=IDLE, PC=RESET_PC, IR=0, halted=0, illegal=0, all outputs 0. In-flight rf_write and mem_write drop immediately.
- alu_sel encodings are fixed: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_PASSB=5.

Decomposition:
- Shared package (core_pkg): opcode constants, ALU_* encodings, state enum, instruction field bit positions, DATA_W/PC_W defaults. The datapath ALU decodes the same ALU_* constants.
- One natural sub-module: instr_decoder, a combinational IR -> control bundle plus is_wb/is_branch/is_illegal. The FSM and PC stay in datapath_sequencer.

Test Plan:
- Reset then run=1, ROM[0]=LDI r1,0x0005 -> imem_addr=0 in FETCH; in WB rf_write=1, rd=1, imm_sel=1, alu_sel=5, imm_data=0x0005; PC_out=1 after 4 cycles.
- ROM[1]=ADD r3,r1,r2 -> EXEC/WB alu_sel=0, rs=1, rt=2, rd=3, rf_write high only in WB; ROM[2]=STI r3,0x00AA -> single-cycle mem_write, mem_data=0x00AA, rf_write=0.
- BEQ r1,r2,imm=0x14 with zero_flag=1 -> next FETCH at imem_addr=20; repeat with zero_flag=0 -> PC+1; BGT with pos_flag=1 taken.
- PC=31 executing NOP -> next imem_addr=0; opcode 0x10 -> executes as NOP, illegal=1 and stays 1 across later instructions.
- HALT at ROM[4] -> halted=1, PC_out stays 4, no further imem fetch changes, rf_write/mem_write stay 0 for 20 cycles.
- Drop run during EXEC of ADD -> WB still writes, then IDLE; assert reset low during WB -> rf_write=0 immediately, PC_out=0, state IDLE.
